// File: rtl/comp_nb_seq.sv
// -----------------------------------------------------------------------------
// comp_nb_seq
// Sequential magnitude comparator. Two W-bit operands are latched on an
// accepted start pulse and compared CHUNK bits per clock, most significant
// chunk first. With EARLY_EXIT set the comparison finishes on the first
// differing chunk; otherwise all chunks are always walked. Two's-complement
// operands are handled by flipping the MSB at latch time (offset binary), so
// the per-chunk compare is always unsigned.
//
// Parameters:
//   W          operand width (W >= 2, W % CHUNK == 0)
//   CHUNK      bits compared per clock (1..W)
//   SIGNED     0 = unsigned, 1 = two's-complement compare
//   EARLY_EXIT 1 = stop at first difference, 0 = always process all chunks
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   comparison request, honoured only while idle
//   a, b   in   operands, sampled on the accepted start edge only
//   busy   out  comparison in progress
//   done   out  one-cycle pulse when eq/lt/gt have just been written
//   eq     out  A == B   (registered, held until next result or reset)
//   lt     out  A <  B
//   gt     out  A >  B
// -----------------------------------------------------------------------------
module comp_nb_seq #(
    parameter int W          = 8,
    parameter int CHUNK      = 1,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    localparam int N    = W / CHUNK;
    localparam int IDXW = $clog2(N + 1);

    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(32'd1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [W-1:0] MSB_MASK = (SIGNED != 0) ? {1'b1, {(W-1){1'b0}}}
                                                      : {W{1'b0}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              dec_q, dec_d;        // a differing chunk has been seen
    logic              dec_gt_q, dec_gt_d;  // direction of that first difference
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              gt_q, gt_d;

    logic [CHUNK-1:0]  chunk_a_s;
    logic [CHUNK-1:0]  chunk_b_s;
    logic              chunk_diff_s;
    logic              chunk_gt_s;
    logic              last_s;

    // Current chunk: operands are shifted left each RUN cycle, so the chunk
    // under test always sits in the top CHUNK bits.
    always_comb begin
        chunk_a_s    = a_q[W-1 -: CHUNK];
        chunk_b_s    = b_q[W-1 -: CHUNK];
        chunk_diff_s = (chunk_a_s != chunk_b_s);
        chunk_gt_s   = (chunk_a_s > chunk_b_s);
        last_s       = (idx_q == IDX_LAST);
    end

    // Next-state and next-output computation for the IDLE/RUN controller.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        dec_d    = dec_q;
        dec_gt_d = dec_gt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        eq_d     = eq_q;
        lt_d     = lt_q;
        gt_d     = gt_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d      = a ^ MSB_MASK;
                    b_d      = b ^ MSB_MASK;
                    idx_d    = {IDXW{1'b0}};
                    dec_d    = 1'b0;
                    dec_gt_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end

            S_RUN: begin
                a_d   = a_q << CHUNK;
                b_d   = b_q << CHUNK;
                idx_d = idx_q + IDX_ONE;
                if (!dec_q && chunk_diff_s) begin
                    if ((EARLY_EXIT != 0) || last_s) begin
                        eq_d    = 1'b0;
                        lt_d    = !chunk_gt_s;
                        gt_d    = chunk_gt_s;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        // Remember only the first difference; later chunks
                        // cannot change the outcome.
                        dec_d    = 1'b1;
                        dec_gt_d = chunk_gt_s;
                        busy_d   = 1'b1;
                    end
                end else if (last_s) begin
                    eq_d    = !dec_q;
                    lt_d    = dec_q && !dec_gt_q;
                    gt_d    = dec_q && dec_gt_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any comparison in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            idx_q    <= {IDXW{1'b0}};
            dec_q    <= 1'b0;
            dec_gt_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            dec_q    <= dec_d;
            dec_gt_q <= dec_gt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign lt   = lt_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_comp_nb_seq.sv
// -----------------------------------------------------------------------------
// Directed bench for comp_nb_seq. Four configurations run side by side on one
// clock and one reset:
//   unit 0: W=8 CHUNK=1 unsigned early-exit
//   unit 1: W=8 CHUNK=1 unsigned full-walk
//   unit 2: W=8 CHUNK=1 signed   early-exit
//   unit 3: W=8 CHUNK=4 unsigned early-exit
// Latency is counted in edges after the start edge E0: a result of latency L
// shows done=1 when sampled on the falling edge following E(L).
// Flags are packed {eq, lt, gt}.
// -----------------------------------------------------------------------------
module tb_comp_nb_seq;

    logic       clk;
    logic       rst;
    logic [3:0] start;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] eq;
    logic [3:0] lt;
    logic [3:0] gt;

    int checks;
    int errors;

    comp_nb_seq #(.W(8), .CHUNK(1), .SIGNED(0), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst(rst), .start(start[0]), .a(a), .b(b),
        .busy(busy[0]), .done(done[0]), .eq(eq[0]), .lt(lt[0]), .gt(gt[0]));

    comp_nb_seq #(.W(8), .CHUNK(1), .SIGNED(0), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .start(start[1]), .a(a), .b(b),
        .busy(busy[1]), .done(done[1]), .eq(eq[1]), .lt(lt[1]), .gt(gt[1]));

    comp_nb_seq #(.W(8), .CHUNK(1), .SIGNED(1), .EARLY_EXIT(1)) u_sgn (
        .clk(clk), .rst(rst), .start(start[2]), .a(a), .b(b),
        .busy(busy[2]), .done(done[2]), .eq(eq[2]), .lt(lt[2]), .gt(gt[2]));

    comp_nb_seq #(.W(8), .CHUNK(4), .SIGNED(0), .EARLY_EXIT(1)) u_c4 (
        .clk(clk), .rst(rst), .start(start[3]), .a(a), .b(b),
        .busy(busy[3]), .done(done[3]), .eq(eq[3]), .lt(lt[3]), .gt(gt[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one comparison on unit u and watch a fixed 20-cycle window.
    // lat stays -1 if no done is seen inside the window.
    task automatic do_compare(input int u, input logic [7:0] av, input logic [7:0] bv,
                              output int lat, output int nbusy, output int ndone,
                              output logic [2:0] fl);
        lat   = -1;
        nbusy = 0;
        ndone = 0;
        fl    = 3'b000;
        @(negedge clk);
        a        = av;
        b        = bv;
        start[u] = 1'b1;
        @(posedge clk);
        #1;
        start[u] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy[u]) nbusy++;
            if (done[u]) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    fl  = {eq[u], lt[u], gt[u]};
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 4'b0000;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            checks++;
            if ({busy[u], done[u], eq[u], lt[u], gt[u]} !== 5'b00000) begin
                errors++;
                $display("FAIL reset_state unit%0d: got %b, expected 00000", u,
                         {busy[u], done[u], eq[u], lt[u], gt[u]});
            end
        end
        // Reset and start in the same cycle: reset wins.
        rst      = 1'b1;
        start[0] = 1'b1;
        a        = 8'h01;
        b        = 8'h02;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        start[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_start busy: got %b, expected 0", busy[0]);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({done[0], eq[0], lt[0], gt[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_with_start no_result: got %b, expected 0000",
                     {done[0], eq[0], lt[0], gt[0]});
        end
    endtask

    task automatic test_equal();
        int lat, nb, nd;
        logic [2:0] fl;
        do_compare(0, 8'h5A, 8'h5A, lat, nb, nd, fl);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL equal latency: got %0d, expected 8", lat); end
        checks++;
        if (nb !== 8) begin errors++; $display("FAIL equal busy_cycles: got %0d, expected 8", nb); end
        checks++;
        if (fl !== 3'b100) begin errors++; $display("FAIL equal flags: got %b, expected 100", fl); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL equal done_pulses: got %0d, expected 1", nd); end
        do_compare(1, 8'hC3, 8'hC3, lat, nb, nd, fl);
        checks++;
        if ({lat, fl} !== {32'd8, 3'b100}) begin
            errors++;
            $display("FAIL equal_full lat/flags: got %0d/%b, expected 8/100", lat, fl);
        end
    endtask

    task automatic test_early_exit();
        int lat, nb, nd;
        logic [2:0] fl;
        do_compare(0, 8'h80, 8'h7F, lat, nb, nd, fl);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL early_exit latency: got %0d, expected 1", lat); end
        checks++;
        if (fl !== 3'b001) begin errors++; $display("FAIL early_exit flags: got %b, expected 001", fl); end
        checks++;
        if (nb !== 1) begin errors++; $display("FAIL early_exit busy_cycles: got %0d, expected 1", nb); end
        do_compare(1, 8'h80, 8'h7F, lat, nb, nd, fl);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL full_walk latency: got %0d, expected 8", lat); end
        checks++;
        if (fl !== 3'b001) begin errors++; $display("FAIL full_walk flags: got %b, expected 001", fl); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL full_walk done_pulses: got %0d, expected 1", nd); end
    endtask

    task automatic test_signed();
        int lat, nb, nd;
        logic [2:0] fl;
        do_compare(2, 8'h80, 8'h7F, lat, nb, nd, fl);
        checks++;
        if ({lat, fl} !== {32'd1, 3'b010}) begin
            errors++;
            $display("FAIL signed_neg_pos lat/flags: got %0d/%b, expected 1/010", lat, fl);
        end
        do_compare(2, 8'hFF, 8'hFE, lat, nb, nd, fl);
        checks++;
        if ({lat, fl} !== {32'd8, 3'b001}) begin
            errors++;
            $display("FAIL signed_m1_m2 lat/flags: got %0d/%b, expected 8/001", lat, fl);
        end
    endtask

    task automatic test_chunk4();
        int lat, nb, nd;
        logic [2:0] fl;
        do_compare(3, 8'hA0, 8'h3F, lat, nb, nd, fl);
        checks++;
        if ({lat, fl} !== {32'd1, 3'b001}) begin
            errors++;
            $display("FAIL chunk4_top lat/flags: got %0d/%b, expected 1/001", lat, fl);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, nd2;
        logic [2:0] fl1, fl2;
        lat1 = -1;
        lat2 = -1;
        nd2  = 0;
        fl1  = 3'b000;
        fl2  = 3'b000;
        @(negedge clk);
        a        = 8'h3C;
        b        = 8'h3D;
        start[3] = 1'b1;
        @(posedge clk);
        #1;
        start[3] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done[3]) begin
                lat1     = c;
                fl1      = {eq[3], lt[3], gt[3]};
                a        = 8'h10;
                b        = 8'h10;
                start[3] = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        start[3] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done[3]) begin
                nd2++;
                if (lat2 < 0) begin
                    lat2 = c;
                    fl2  = {eq[3], lt[3], gt[3]};
                end
            end
        end
        checks++;
        if ({lat1, fl1} !== {32'd2, 3'b010}) begin
            errors++;
            $display("FAIL b2b_first lat/flags: got %0d/%b, expected 2/010", lat1, fl1);
        end
        checks++;
        if ({lat2, fl2} !== {32'd2, 3'b100}) begin
            errors++;
            $display("FAIL b2b_second lat/flags: got %0d/%b, expected 2/100", lat2, fl2);
        end
        checks++;
        if (nd2 !== 1) begin errors++; $display("FAIL b2b_second done_pulses: got %0d, expected 1", nd2); end
    endtask

    task automatic test_handshake();
        int lat, nd;
        logic [2:0] fl;
        lat = -1;
        nd  = 0;
        fl  = 3'b000;
        @(negedge clk);
        a        = 8'h5A;
        b        = 8'h5B;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        a        = 8'hFF;
        b        = 8'h00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done[0]) begin
                nd++;
                if (lat < 0) begin
                    lat = c;
                    fl  = {eq[0], lt[0], gt[0]};
                end
            end
            // Start sampled at E2 and E3 while the compare is running.
            start[0] = (c == 1 || c == 2) ? 1'b1 : 1'b0;
        end
        start[0] = 1'b0;
        checks++;
        if ({lat, fl} !== {32'd8, 3'b010}) begin
            errors++;
            $display("FAIL handshake lat/flags: got %0d/%b, expected 8/010", lat, fl);
        end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL handshake done_pulses: got %0d, expected 1", nd); end
    endtask

    task automatic test_reset_mid();
        int lat, nb, nd;
        logic [2:0] fl;
        nd = 0;
        @(negedge clk);
        a        = 8'h80;
        b        = 8'h7F;
        start[1] = 1'b1;
        @(posedge clk);
        #1;
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy[1], done[1], eq[1], lt[1], gt[1]} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid state: got %b, expected 00000",
                     {busy[1], done[1], eq[1], lt[1], gt[1]});
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done[1]) nd++;
        end
        checks++;
        if (nd !== 0) begin errors++; $display("FAIL reset_mid done_pulses: got %0d, expected 0", nd); end
        do_compare(1, 8'h11, 8'h22, lat, nb, nd, fl);
        checks++;
        if ({lat, fl} !== {32'd8, 3'b010}) begin
            errors++;
            $display("FAIL after_reset lat/flags: got %0d/%b, expected 8/010", lat, fl);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_equal();
        test_early_exit();
        test_signed();
        test_chunk4();
        test_back_to_back();
        test_handshake();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_nb_seq.md
# comp_nb_seq

Parametrised sequential magnitude comparator, the multi-bit successor to the team's 1-bit equality comparator. Accepts two W-bit operands on a start pulse and compares them CHUNK bits per clock, MSB chunk first, with optional early termination on the first differing chunk. Produces registered eq/lt/gt flags plus a busy/done handshake. It sits between the datapath registers and control FSMs that need ordered comparisons without a wide single-cycle comparator.

## Interface
- W, 8: operand width in bits; W ≥ 2, W % CHUNK == 0
- CHUNK, 1: bits compared per clock; 1 ≤ CHUNK ≤ W
- SIGNED, 0: 0 = unsigned compare, 1 = two's-complement compare
- EARLY_EXIT, 1: 1 = finish on the first differing chunk, 0 = always process all chunks
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when idle
- a  in  W  operand A; sampled only on the accepted start edge
- b  in  W  operand B; sampled only on the accepted start edge
- busy  out  1  comparison in progress
- done  out  1  one-cycle pulse when results become valid
- eq  out  1  A == B
- lt  out  1  A < B
- gt  out  1  A > B

## Operation
- N = W/CHUNK chunks. Chunk k (k = 0..N-1) is bits [W-1-k·CHUNK : W-(k+1)·CHUNK].
- States: IDLE and RUN. Chunk index counter: ceil(log2(N+1)) bits.
- IDLE: busy=0. On start=1, latch a and b into internal registers, clear the chunk index, clear done, then enter RUN. eq/lt/gt keep their previous values until the new result is written.
- SIGNED=1: invert the MSB of both latched operands (offset-binary) before comparing. The unsigned chunk compare then gives the signed result.
- RUN, each edge: compare chunk k of A and B as unsigned CHUNK-bit values.
  - Chunks differ: the result is decided (gt if A chunk > B chunk, else lt). With EARLY_EXIT=1, write the flags and go to IDLE. With EARLY_EXIT=0, record the decision, ignore later chunks, and keep running.
  - Chunks equal, or a decision is already recorded: increment k.
  - After chunk N-1: write the flags (eq=1 if no chunk differed) and go to IDLE.
- On every result write: exactly one of eq/lt/gt is 1, and done=1 for exactly one cycle.
- start while busy=1 is ignored, with no queuing. Changes on a/b after the accepted start have no effect.
- Reset (synchronous, any state): state=IDLE, busy=0, done=0, eq=0, lt=0, gt=0, and operand and index registers cleared. A comparison interrupted by reset is discarded and produces no done.

## Timing
- Edge E0: start accepted. busy=1 from E0 until the terminating edge.
- Chunk k is evaluated at edge E(k+1).
- Terminating edge ET: flags updated, busy=0, done=1 during the cycle after ET, done=0 after the next edge.
  - No early exit: ET = EN, so latency is N clocks from the start edge.
  - Early exit with first difference at chunk k: ET = E(k+1), so latency is k+1 clocks (minimum 1).
- Back-to-back operation: start=1 in the done cycle is accepted (state is IDLE). Throughput is one comparison per latency clocks.
- eq/lt/gt are registered, glitch-free, and stable from ET until the next result write or reset.
- Reset asserted in the same cycle as start: reset wins, and start is not accepted.

## Test plan
- Equal operands, W=8, CHUNK=1: a=0x5A, b=0x5A -> busy high for 8 cycles, done at latency 8, eq=1, lt=0, gt=0.
- Early exit, unsigned: W=8, CHUNK=1, EARLY_EXIT=1, a=0x80, b=0x7F -> done at latency 1, gt=1. Same with EARLY_EXIT=0 -> latency 8, gt=1.
- Signed mode: SIGNED=1, a=0x80 (-128), b=0x7F (+127) -> lt=1. Also a=0xFF (-1), b=0xFE (-2) -> gt=1 at latency 8 (first difference at chunk 7).
- CHUNK=4, W=8: a=0x3C, b=0x3D -> done at latency 2, lt=1. Then issue start in the done cycle with a=0x10, b=0x10 -> accepted, eq=1 at latency 2.
- Handshake robustness: start pulses at cycles 2 and 3 of a running compare, and a/b changed after E0 -> ignored; result reflects the operands latched at E0; exactly one done pulse.
- Reset mid-operation: assert rst at RUN cycle 3 -> next edge gives busy=0, eq=lt=gt=0, no done pulse. A new start afterwards completes normally.
